sigmoid_pwl_pipe: RTL and testbench

- Parametrised, 3-stage pipelined piecewise-linear sigmoid evaluator (PLAN segments) with an optional per-sample tanh mode.
- Valid/ready handshakes on both the input and output sides.
- Successor to the single-register sigmoid stage: configurable widths, exact symmetric evaluation and backpressure.
- Sits between the activation-input register bank and the accumulator write-back.

---
 rtl/sigmoid_pwl_pipe.sv | 163 ++++++++++++++++
 tb/tb_sigmoid_pwl_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_pwl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sigmoid_pwl_pipe
// Brief    : 3-stage PLAN piecewise-linear sigmoid / tanh with valid/ready
// Revision : 1.0
// ============================================================================
module sigmoid_pwl_pipe #(
    parameter int IN_W    = 8,
    parameter int IN_FRAC = 4,
    parameter int OUT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [IN_W-1:0]   i_x,
    input  logic              i_mode,
    output logic [OUT_W-1:0]  o_y,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [50:0]       number
);

    localparam int c_MAG_W = IN_W - 1;
    localparam int c_YF    = IN_FRAC + 5;
    localparam int c_YW    = c_YF + 1;
    localparam int c_CW    = ((c_MAG_W > c_YW) ? c_MAG_W : c_YW) + 4;
    localparam int c_TW    = c_YW + 1;
    localparam int c_WW    = c_TW + OUT_W;

    localparam logic [c_MAG_W-1:0] c_MAG_MAX = '1;

    // Thresholds compared against 8*a so that 2.375 stays exact for any IN_FRAC
    localparam logic [c_CW-1:0] c_TH_5    = c_CW'(5 << (IN_FRAC + 3));
    localparam logic [c_CW-1:0] c_TH_2375 = c_CW'(19 << IN_FRAC);
    localparam logic [c_CW-1:0] c_TH_1    = c_CW'(1 << (IN_FRAC + 3));
    localparam logic [c_CW-1:0] c_OFF_HI  = c_CW'(27 << IN_FRAC);
    localparam logic [c_CW-1:0] c_OFF_MID = c_CW'(5 << (IN_FRAC + 2));
    localparam logic [c_CW-1:0] c_OFF_LO  = c_CW'(1 << (IN_FRAC + 4));
    localparam logic [c_CW-1:0] c_ONE     = c_CW'(1 << c_YF);

    localparam logic [c_YW-1:0]  c_Y_ONE = c_YW'(1 << c_YF);
    localparam logic [c_TW-1:0]  c_T_ONE = c_TW'(1 << c_YF);
    localparam logic [OUT_W-1:0] c_T_MAX = {1'b0, {(OUT_W-1){1'b1}}};

    localparam int c_TR_FF   = 24;
    localparam int c_TR_FA   = 28;
    localparam int c_TR_MUX2 = 12;
    localparam int c_N_FF    = (3 + c_MAG_W) + (3 + c_YW) + (1 + OUT_W);
    localparam int c_N_FA    = IN_W + c_YW + c_YW + c_TW;
    localparam int c_N_MUX2  = 3 * c_MAG_W + 4 * c_YW + 2 * OUT_W;
    localparam logic [50:0] c_NUMBER =
        51'(c_N_FF * c_TR_FF + c_N_FA * c_TR_FA + c_N_MUX2 * c_TR_MUX2);

    logic                w_adv;
    logic                w_neg;
    logic [IN_W-1:0]     w_abs_full;
    logic [c_MAG_W-1:0]  w_mag;
    logic [c_MAG_W:0]    w_dbl;
    logic [c_MAG_W-1:0]  w_mag_t;
    logic [c_MAG_W-1:0]  w_a;

    logic                r_s1_v;
    logic                r_s1_neg;
    logic                r_s1_mode;
    logic [c_MAG_W-1:0]  r_s1_a;

    logic [c_CW-1:0]     w_a_ext;
    logic [c_CW-1:0]     w_a8;
    logic [c_CW-1:0]     w_ypos_c;

    logic                r_s2_v;
    logic                r_s2_neg;
    logic                r_s2_mode;
    logic [c_YW-1:0]     r_s2_y;

    logic [c_YW-1:0]         w_y;
    logic [c_WW-1:0]         w_sig_wide;
    logic [c_TW-1:0]         w_t;
    logic signed [c_WW-1:0]  w_t_ext;
    logic signed [c_WW-1:0]  w_t_sh;
    logic [OUT_W-1:0]        w_y_fmt;
    logic                    w_unused;

    logic                r_out_v;
    logic [OUT_W-1:0]    r_y;

    assign w_adv      = !r_out_v | i_out_ready;
    assign o_in_ready = w_adv;
    assign o_out_valid = r_out_v;
    assign o_y        = r_y;
    assign number     = c_NUMBER;

    // Stage 1: magnitude with saturation of |min| and of the tanh doubling
    assign w_neg      = i_x[IN_W-1];
    assign w_abs_full = w_neg ? (~i_x + IN_W'(1)) : i_x;
    assign w_mag      = w_abs_full[IN_W-1] ? c_MAG_MAX : w_abs_full[c_MAG_W-1:0];
    assign w_dbl      = {w_mag, 1'b0};
    assign w_mag_t    = w_dbl[c_MAG_W] ? c_MAG_MAX : w_dbl[c_MAG_W-1:0];
    assign w_a        = i_mode ? w_mag_t : w_mag;

    // Stage 2: a as an integer already equals a/32 in Q1.(IN_FRAC+5)
    assign w_a_ext = {{(c_CW-c_MAG_W){1'b0}}, r_s1_a};
    assign w_a8    = w_a_ext << 3;

    always_comb begin
        w_ypos_c = c_ONE;
        if (w_a8 >= c_TH_5)
            w_ypos_c = c_ONE;
        else if (w_a8 >= c_TH_2375)
            w_ypos_c = w_a_ext + c_OFF_HI;
        else if (w_a8 >= c_TH_1)
            w_ypos_c = (w_a_ext << 2) + c_OFF_MID;
        else
            w_ypos_c = w_a8 + c_OFF_LO;
    end

    // Stage 3: symmetric fold, then floor-rescale to OUT_W-1 fraction bits
    assign w_y        = r_s2_neg ? (c_Y_ONE - r_s2_y) : r_s2_y;
    assign w_sig_wide = ({{(c_WW-c_YW){1'b0}}, w_y} << (OUT_W - 1)) >> c_YF;
    assign w_t        = {w_y, 1'b0} - c_T_ONE;
    assign w_t_ext    = $signed({{(c_WW-c_TW){w_t[c_TW-1]}}, w_t});
    assign w_t_sh     = (w_t_ext <<< (OUT_W - 1)) >>> c_YF;
    assign w_y_fmt    = r_s2_mode ? ((w_t == c_T_ONE) ? c_T_MAX : w_t_sh[OUT_W-1:0])
                                  : w_sig_wide[OUT_W-1:0];

    assign w_unused = ^{w_ypos_c[c_CW-1:c_YW], w_sig_wide[c_WW-1:OUT_W],
                        w_t_sh[c_WW-1:OUT_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_neg  <= 1'b0;
            r_s1_mode <= 1'b0;
            r_s1_a    <= '0;
            r_s2_v    <= 1'b0;
            r_s2_neg  <= 1'b0;
            r_s2_mode <= 1'b0;
            r_s2_y    <= '0;
            r_out_v   <= 1'b0;
            r_y       <= '0;
        end else if (w_adv) begin
            r_s1_v  <= i_in_valid;
            r_s2_v  <= r_s1_v;
            r_out_v <= r_s2_v;
            if (i_in_valid) begin
                r_s1_neg  <= w_neg;
                r_s1_mode <= i_mode;
                r_s1_a    <= w_a;
            end
            if (r_s1_v) begin
                r_s2_neg  <= r_s1_neg;
                r_s2_mode <= r_s1_mode;
                r_s2_y    <= w_ypos_c[c_YW-1:0];
            end
            // o_y only moves when a real sample lands, so it holds across bubbles
            if (r_s2_v)
                r_y <= w_y_fmt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_pwl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigmoid_pwl_pipe
// Brief    : directed and random self-checking bench for sigmoid_pwl_pipe
// Revision : 1.0
// ============================================================================
module tb_sigmoid_pwl_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [7:0]  i_x;
    logic        i_mode;
    logic [15:0] o_y;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [50:0] number;

    int n_checks = 0;
    int n_errors = 0;

    sigmoid_pwl_pipe #(.IN_W(8), .IN_FRAC(4), .OUT_W(16)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_x         (i_x),
        .i_mode      (i_mode),
        .o_y         (o_y),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .number      (number)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference in units of 1/512 for the default Q4.4 -> Q1.15 configuration
    function automatic logic [15:0] model(input logic [7:0] x, input logic mode);
        int xi, a, y, t;
        bit s;
        xi = int'($signed(x));
        s  = (xi < 0);
        a  = s ? -xi : xi;
        if (a > 127) a = 127;
        if (mode) begin
            a = 2 * a;
            if (a > 127) a = 127;
        end
        if (a >= 80)      y = 512;
        else if (a >= 38) y = a + 432;
        else if (a >= 16) y = 4 * a + 320;
        else              y = 8 * a + 256;
        if (s) y = 512 - y;
        if (!mode) return 16'(y * 64);
        t = 2 * y - 512;
        if (t == 512) return 16'h7FFF;
        return 16'(t * 64);
    endfunction

    // Called at a negedge; checks 3-cycle latency and a single valid pulse
    task automatic run_one(input string tag, input logic [7:0] x, input logic m,
                           input logic [15:0] exp);
        i_in_valid = 1'b1;
        i_x        = x;
        i_mode     = m;
        @(negedge clk);
        i_in_valid = 1'b0;
        check({tag, "_lat1"}, o_out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_lat2"}, o_out_valid, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, o_out_valid, 1'b1);
        check({tag, "_y"}, o_y, exp);
        @(negedge clk);
        check({tag, "_once"}, o_out_valid, 1'b0);
    endtask

    logic [7:0]  bp_in  [4];
    logic [15:0] bp_exp [4];
    logic [7:0]  edge_x [8];
    logic [15:0] exp_q  [$];
    logic [50:0] num0;

    initial begin
        int ii, oi, sent, cyc, stale;
        bp_in  = '{8'h00, 8'h10, 8'hF0, 8'h50};
        bp_exp = '{16'h4000, 16'h6000, 16'h2000, 16'h8000};
        edge_x = '{8'h25, 8'h26, 8'hDA, 8'h50, 8'h4F, 8'h10, 8'h0F, 8'h80};

        rst = 1'b1; i_in_valid = 1'b0; i_x = 8'h00; i_mode = 1'b0; i_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", o_out_valid, 1'b0);
        check("rst_y", o_y, 16'h0000);
        rst = 1'b0;
        #1;
        check("rst_in_ready", o_in_ready, 1'b1);
        check("number_nz", number != 51'd0, 1'b1);
        num0 = number;
        @(negedge clk);

        run_one("sig_00", 8'h00, 1'b0, 16'h4000);
        run_one("sig_10", 8'h10, 1'b0, 16'h6000);
        run_one("sig_F0", 8'hF0, 1'b0, 16'h2000);
        run_one("sig_50", 8'h50, 1'b0, 16'h8000);
        run_one("sig_80", 8'h80, 1'b0, 16'h0000);
        run_one("bp_25",  8'h25, 1'b0, 16'h7500);
        run_one("bp_26",  8'h26, 1'b0, 16'h7580);
        run_one("bp_DA",  8'hDA, 1'b0, 16'h0A80);
        run_one("tanh_08", 8'h08, 1'b1, 16'h4000);
        run_one("tanh_00", 8'h00, 1'b1, 16'h0000);
        run_one("tanh_40", 8'h40, 1'b1, 16'h7FFF);
        run_one("tanh_C0", 8'hC0, 1'b1, 16'h8000);
        run_one("tanh_80", 8'h80, 1'b1, 16'h8000);

        // Backpressure: stall the sink for 5 cycles mid-stream
        ii = 0; oi = 0;
        for (int c = 0; c < 30; c++) begin
            i_out_ready = !(c >= 3 && c < 8);
            i_in_valid  = (ii < 4);
            i_x         = bp_in[(ii < 4) ? ii : 3];
            i_mode      = 1'b0;
            #1;
            if (o_out_valid && !i_out_ready) begin
                check("bp_in_ready", o_in_ready, 1'b0);
                check("bp_hold", o_y, bp_exp[(oi < 4) ? oi : 3]);
            end
            if (i_in_valid && o_in_ready) ii++;
            if (o_out_valid && i_out_ready) begin
                if (oi < 4) check("bp_out", o_y, bp_exp[oi]);
                oi++;
            end
            @(negedge clk);
        end
        i_in_valid = 1'b0; i_out_ready = 1'b1;
        check("bp_sent", ii, 4);
        check("bp_count", oi, 4);

        // Reset with three samples in flight
        for (int c = 0; c < 3; c++) begin
            i_in_valid = 1'b1;
            i_x        = bp_in[c];
            @(negedge clk);
        end
        i_in_valid = 1'b0;
        check("mid_pre_valid", o_out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", o_out_valid, 1'b0);
        check("mid_rst_y", o_y, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_out_valid) stale++;
        end
        check("mid_no_stale", stale, 0);
        run_one("mid_next", 8'h10, 1'b0, 16'h6000);

        // Random stream with random backpressure
        sent = 0; cyc = 0;
        while ((sent < 10000 || exp_q.size() != 0) && cyc < 60000) begin
            i_out_ready = ($urandom_range(3) != 0);
            if (sent < 10000) begin
                i_in_valid = ($urandom_range(9) < 7);
                if ($urandom_range(3) == 0) i_x = edge_x[$urandom_range(7)];
                else                        i_x = 8'($urandom);
                i_mode = 1'($urandom_range(1));
            end else begin
                i_in_valid = 1'b0;
            end
            #1;
            if (i_in_valid && o_in_ready) begin
                exp_q.push_back(model(i_x, i_mode));
                sent++;
            end
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) check("rnd_extra", o_out_valid, 1'b0);
                else                   check("rnd_y", o_y, exp_q.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        check("rnd_sent", sent, 10000);
        check("rnd_drain", exp_q.size(), 0);
        check("number_const", number, num0);
        check("number_nz_end", number != 51'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
